// File: rtl/wb_modport_interconnect.sv
// -----------------------------------------------------------------------------
// wb_modport_interconnect
//
// Purpose:
//   Wishbone classic single-master to N-slave address decoder. The upstream
//   master is steered to the one slave whose window [BASE, BASE+SPACE)
//   contains the address. The window base is stripped, so each slave sees a
//   local word address. An access that falls in no window is answered by a
//   small internal error responder.
//
//   The forward path (master to slaves) is purely combinational. The return
//   path (slaves to master) is a combinational AND-OR mux. The only state in
//   the block is the error responder flop.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   s_*             : upstream Wishbone slave port (connects to the master)
//                     adr, dat_i, dat_o, we, stb, cyc, ack, err
//   m_clk, m_rst    : clock and reset fanned out to each downstream slave
//   m_*             : flattened downstream master ports, one slot per slave;
//                     slot j occupies [j*W +: W] of each vector
// -----------------------------------------------------------------------------
module wb_modport_interconnect #(
    parameter int INSTANCES  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [INSTANCES*ADDR_WIDTH-1:0] BASE_ADDRESS = {32'd1024, 32'd0},
    parameter logic [INSTANCES*ADDR_WIDTH-1:0] MEMORY_SPACE = {32'd256, 32'd256}
) (
    input  logic                             clk,
    input  logic                             rst,
    // upstream master side
    input  logic [ADDR_WIDTH-1:0]            s_adr,
    input  logic [DATA_WIDTH-1:0]            s_dat_i,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    input  logic                             s_we,
    input  logic                             s_stb,
    input  logic                             s_cyc,
    output logic                             s_ack,
    output logic                             s_err,
    // downstream slave side
    output logic [INSTANCES-1:0]             m_clk,
    output logic [INSTANCES-1:0]             m_rst,
    output logic [INSTANCES*ADDR_WIDTH-1:0]  m_adr,
    output logic [INSTANCES*DATA_WIDTH-1:0]  m_dat_i,
    input  logic [INSTANCES*DATA_WIDTH-1:0]  m_dat_o,
    output logic [INSTANCES-1:0]             m_we,
    output logic [INSTANCES-1:0]             m_stb,
    output logic [INSTANCES-1:0]             m_cyc,
    input  logic [INSTANCES-1:0]             m_ack
);

    // -------------------------------------------------------------------------
    // Elaboration-time window map checks
    // -------------------------------------------------------------------------
    // Window arithmetic uses one extra bit so that BASE+SPACE cannot wrap.
    function automatic logic [ADDR_WIDTH:0] f_base(input int j);
        return {1'b0, BASE_ADDRESS[j*ADDR_WIDTH +: ADDR_WIDTH]};
    endfunction

    function automatic logic [ADDR_WIDTH:0] f_space(input int j);
        return {1'b0, MEMORY_SPACE[j*ADDR_WIDTH +: ADDR_WIDTH]};
    endfunction

    function automatic bit f_any_overlap();
        bit found;
        found = 1'b0;
        for (int a = 0; a < INSTANCES; a++) begin
            for (int b = a + 1; b < INSTANCES; b++) begin
                if ((f_base(a) < f_base(b) + f_space(b)) &&
                    (f_base(b) < f_base(a) + f_space(a))) begin
                    found = 1'b1;
                end
            end
        end
        return found;
    endfunction

    function automatic bit f_any_not_pow2();
        bit found;
        found = 1'b0;
        for (int j = 0; j < INSTANCES; j++) begin
            if ((f_space(j) == '0) ||
                ((f_space(j) & (f_space(j) - 1'b1)) != '0)) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    function automatic bit f_any_misaligned();
        bit found;
        found = 1'b0;
        for (int j = 0; j < INSTANCES; j++) begin
            if ((f_space(j) != '0) && ((f_base(j) % f_space(j)) != '0)) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    localparam bit P_OVERLAP    = f_any_overlap();
    localparam bit P_NOT_POW2   = f_any_not_pow2();
    localparam bit P_MISALIGNED = f_any_misaligned();

    if (P_OVERLAP) begin : g_chk_overlap
        $error("wb_modport_interconnect: two slave address windows overlap");
    end
    if (P_NOT_POW2) begin : g_chk_pow2
        $error("wb_modport_interconnect: a MEMORY_SPACE entry is not a power of two");
    end
    if (P_MISALIGNED) begin : g_chk_align
        $error("wb_modport_interconnect: a BASE_ADDRESS is not a multiple of its MEMORY_SPACE");
    end

    // -------------------------------------------------------------------------
    // Per-slot decode and forward path
    // -------------------------------------------------------------------------
    logic [INSTANCES-1:0] w_match;

    for (genvar gi = 0; gi < INSTANCES; gi++) begin : g_slot
        localparam logic [ADDR_WIDTH-1:0] BASE  = BASE_ADDRESS[gi*ADDR_WIDTH +: ADDR_WIDTH];
        localparam logic [ADDR_WIDTH-1:0] SPACE = MEMORY_SPACE[gi*ADDR_WIDTH +: ADDR_WIDTH];
        // Number of local (in-window) address bits.
        localparam int MW = $clog2(SPACE);
        // Mask selecting the local address bits; empty for a one-word window.
        localparam logic [ADDR_WIDTH-1:0] MASK =
            (MW == 0) ? '0 : ({ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - MW));

        // Shifting both sides compares only the bits above the window, and
        // degenerates to a full-address compare when MW is zero.
        assign w_match[gi] = ((s_adr >> MW) == (BASE >> MW));

        assign m_adr[gi*ADDR_WIDTH +: ADDR_WIDTH]   = s_adr & MASK;
        assign m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
        assign m_we[gi]  = s_we;
        assign m_stb[gi] = s_stb & w_match[gi];
        assign m_cyc[gi] = s_cyc & w_match[gi];
        assign m_clk[gi] = clk;
        assign m_rst[gi] = rst;
    end

    logic w_any_match;
    assign w_any_match = |w_match;

    // -------------------------------------------------------------------------
    // Return path: AND-OR mux over the matching slot
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_dat;
    logic                  w_rd_ack;

    always_comb begin
        w_rd_dat = '0;
        w_rd_ack = 1'b0;
        for (int j = 0; j < INSTANCES; j++) begin
            w_rd_dat = w_rd_dat | ({DATA_WIDTH{w_match[j]}} & m_dat_o[j*DATA_WIDTH +: DATA_WIDTH]);
            w_rd_ack = w_rd_ack | (w_match[j] & m_ack[j]);
        end
    end

    // -------------------------------------------------------------------------
    // Unmapped-access error responder
    // -------------------------------------------------------------------------
    // The ~r_err_q term makes the flop drop after each error ack, so a request
    // that stays asserted is answered on every other cycle instead of
    // continuously.
    logic r_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= s_cyc & s_stb & ~w_any_match & ~r_err_q;
        end
    end

    // A pending error response takes priority over any slave, even if the
    // master has meanwhile moved to a mapped address.
    assign s_ack   = r_err_q | w_rd_ack;
    assign s_err   = r_err_q;
    assign s_dat_o = r_err_q ? '0 : w_rd_dat;

endmodule

// File: tb/tb_wb_modport_interconnect.sv
// -----------------------------------------------------------------------------
// tb_wb_modport_interconnect
//
// Directed bench for wb_modport_interconnect with the default window map:
//   slot0 = [0x000, 0x100), slot1 = [0x400, 0x500), everything else unmapped.
// Inputs change 1 time unit after a rising edge; outputs are checked a
// further 1 time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_wb_modport_interconnect;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_i;
    logic [DW-1:0]   s_dat_o;
    logic            s_we;
    logic            s_stb;
    logic            s_cyc;
    logic            s_ack;
    logic            s_err;
    logic [N-1:0]    m_clk;
    logic [N-1:0]    m_rst;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_i;
    logic [N*DW-1:0] m_dat_o;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_stb;
    logic [N-1:0]    m_cyc;
    logic [N-1:0]    m_ack;

    int n_cmp = 0;
    int n_err = 0;

    wb_modport_interconnect #(
        .INSTANCES    (N),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BASE_ADDRESS ({32'd1024, 32'd0}),
        .MEMORY_SPACE ({32'd256, 32'd256})
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_adr   (s_adr),
        .s_dat_i (s_dat_i),
        .s_dat_o (s_dat_o),
        .s_we    (s_we),
        .s_stb   (s_stb),
        .s_cyc   (s_cyc),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .m_clk   (m_clk),
        .m_rst   (m_rst),
        .m_adr   (m_adr),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_we    (m_we),
        .m_stb   (m_stb),
        .m_cyc   (m_cyc),
        .m_ack   (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop the request so the next edge does not arm the error responder.
    task automatic idle();
        s_stb = 1'b0;
        s_cyc = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst     = 1'b1;
        s_adr   = '0;
        s_dat_i = '0;
        s_we    = 1'b0;
        s_stb   = 1'b0;
        s_cyc   = 1'b0;
        m_dat_o = '0;
        m_ack   = '0;
        step();
        step();
        check("rst_ack",   {63'd0, s_ack}, 64'd0);
        check("rst_err",   {63'd0, s_err}, 64'd0);
        check("rst_dat",   {32'd0, s_dat_o}, 64'd0);
        check("rst_fanout",{62'd0, m_rst}, 64'd3);
        rst = 1'b0;
        #1;
        check("rst_release",{62'd0, m_rst}, 64'd0);

        // ---------------- write to slot0 ----------------
        step();
        s_adr   = 32'h0000_0004;
        s_dat_i = 32'hDEAD_BEEF;
        s_we    = 1'b1;
        s_stb   = 1'b1;
        s_cyc   = 1'b1;
        m_ack   = 2'b00;
        #1;
        check("wr_stb",    {62'd0, m_stb}, 64'd1);
        check("wr_cyc",    {62'd0, m_cyc}, 64'd1);
        // write enable is broadcast; only the strobed slave acts on it
        check("wr_we",     {62'd0, m_we}, 64'd3);
        check("wr_adr0",   {32'd0, m_adr[31:0]}, 64'd4);
        check("wr_dat0",   {32'd0, m_dat_i[31:0]}, 64'hDEAD_BEEF);
        check("wr_noack",  {63'd0, s_ack}, 64'd0);
        m_ack = 2'b01;
        #1;
        check("wr_ack",    {63'd0, s_ack}, 64'd1);
        check("wr_err",    {63'd0, s_err}, 64'd0);
        idle();
        m_ack = 2'b00;

        // ---------------- read from slot1 ----------------
        step();
        s_adr   = 32'h0000_0404;
        s_we    = 1'b0;
        s_stb   = 1'b1;
        s_cyc   = 1'b1;
        m_dat_o = {32'h1234_5678, 32'hAAAA_AAAA};
        m_ack   = 2'b11;  // slot0 ack is spurious
        #1;
        check("rd_stb",    {62'd0, m_stb}, 64'd2);
        check("rd_adr1",   {32'd0, m_adr[63:32]}, 64'd4);
        check("rd_dat",    {32'd0, s_dat_o}, 64'h1234_5678);
        check("rd_ack",    {63'd0, s_ack}, 64'd1);
        m_ack = 2'b01;    // only the spurious ack remains
        #1;
        check("rd_spur_ack",{63'd0, s_ack}, 64'd0);
        idle();
        m_ack   = 2'b00;
        m_dat_o = '0;

        // ---------------- window boundaries ----------------
        step();
        s_adr = 32'h0000_00FF; s_stb = 1'b1; s_cyc = 1'b1;
        #1;
        check("bnd_ff_stb", {62'd0, m_stb}, 64'd1);
        check("bnd_ff_adr0",{32'd0, m_adr[31:0]}, 64'hFF);
        idle();

        step();
        s_adr = 32'h0000_0100; s_stb = 1'b1; s_cyc = 1'b1;
        #1;
        check("bnd_100_stb",{62'd0, m_stb}, 64'd0);
        check("bnd_100_ack",{63'd0, s_ack}, 64'd0);
        idle();

        step();
        s_adr = 32'h0000_03FF; s_stb = 1'b1; s_cyc = 1'b1;
        #1;
        check("bnd_3ff_stb",{62'd0, m_stb}, 64'd0);
        idle();

        step();
        s_adr = 32'h0000_0400; s_stb = 1'b1; s_cyc = 1'b1;
        #1;
        check("bnd_400_stb",{62'd0, m_stb}, 64'd2);
        check("bnd_400_adr1",{32'd0, m_adr[63:32]}, 64'd0);
        idle();

        // ---------------- unmapped read, strobe held ----------------
        step();
        s_adr   = 32'h0000_0200;
        s_we    = 1'b0;
        s_stb   = 1'b1;
        s_cyc   = 1'b1;
        m_dat_o = {32'h5555_5555, 32'h6666_6666};
        #1;
        check("um_stb",    {62'd0, m_stb}, 64'd0);
        check("um_c0_ack", {63'd0, s_ack}, 64'd0);
        step();
        check("um_c1_ack", {63'd0, s_ack}, 64'd1);
        check("um_c1_err", {63'd0, s_err}, 64'd1);
        check("um_c1_dat", {32'd0, s_dat_o}, 64'd0);
        step();
        check("um_c2_ack", {63'd0, s_ack}, 64'd0);
        check("um_c2_err", {63'd0, s_err}, 64'd0);
        step();
        check("um_c3_ack", {63'd0, s_ack}, 64'd1);
        // move to a mapped window while the error response is pending
        s_adr = 32'h0000_0004;
        m_ack = 2'b00;
        #1;
        check("um_mv_stb", {62'd0, m_stb}, 64'd1);
        check("um_mv_ack", {63'd0, s_ack}, 64'd1);
        check("um_mv_err", {63'd0, s_err}, 64'd1);
        check("um_mv_dat", {32'd0, s_dat_o}, 64'd0);
        idle();
        step();
        check("um_done_err",{63'd0, s_err}, 64'd0);

        // ---------------- reset during unmapped request ----------------
        s_adr = 32'h0000_0200;
        s_stb = 1'b1;
        s_cyc = 1'b1;
        rst   = 1'b1;
        step();
        check("rstum_ack", {63'd0, s_ack}, 64'd0);
        check("rstum_err", {63'd0, s_err}, 64'd0);
        rst = 1'b0;
        step();
        check("rstum_rec_err",{63'd0, s_err}, 64'd1);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
